// File: rtl/uart_tx_arbiter_if.sv
// Byte-port bundle between NUM_REQ requesters, the arbiter and the UART TX
// serializer.
//
// Handshake rule (both sides): a byte moves on a rising edge where valid and
// ready are both high. The sender keeps valid and data stable until that edge.
// Ready may depend combinationally on valid.
//
// Modports:
//   master - client/transmitter side; drives requests and tx_ready.
//   slave  - arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic [IDX_W-1:0]          tx_src;
  logic                      tx_ready;
  logic                      busy;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_src, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, tx_src, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte port between NUM_REQ
// requesters. One byte per grant; the accepted byte is registered and held
// on tx_* until the transmitter takes it.
//
// Optional feature: define UART_ARB_LOCK_EN to keep the grant with one
// requester until it sends a byte flagged req_last, so messages from
// different requesters never interleave. Without it req_last is ignored.
//
// IDX_W must equal clog2(NUM_REQ).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef UART_ARB_LOCK_EN
    S_LOCK = 2'd2,
`endif
    S_SEND = 2'd1
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_tx_data;
  logic [IDX_W-1:0]    r_tx_src;
`ifdef UART_ARB_LOCK_EN
  logic                r_last;
`else
  logic                w_unused_last;
  assign w_unused_last = ^bus.req_last;
`endif

  logic                w_win_found;
  logic [IDX_W-1:0]    w_win_idx;
  logic [IDX_W-1:0]    w_cand;
  logic                w_accept;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_tx_fire;

  assign w_tx_fire = r_tx_valid & bus.tx_ready;

  // Round-robin scan: first valid requester after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_win_found && bus.req_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // Grant decision: open arbitration in IDLE, owner-only while locked.
  always_comb begin
    w_accept    = 1'b0;
    w_grant_idx = w_win_idx;
    case (r_state)
      S_IDLE: w_accept = w_win_found;
`ifdef UART_ARB_LOCK_EN
      S_LOCK: begin
        w_grant_idx = r_tx_src;
        w_accept    = bus.req_valid[r_tx_src];
      end
`endif
      default: w_accept = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_SEND;
      S_SEND: begin
        if (w_tx_fire) begin
`ifdef UART_ARB_LOCK_EN
          w_next = r_last ? S_IDLE : S_LOCK;
`else
          w_next = S_IDLE;
`endif
        end
      end
`ifdef UART_ARB_LOCK_EN
      S_LOCK: if (w_accept) w_next = S_SEND;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: one-hot ready to the granted requester, never during reset.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && w_accept) bus.req_ready[w_grant_idx] = 1'b1;
    bus.busy = (r_state != S_IDLE);
  end

  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_src   = r_tx_src;
  assign o_dbg_state  = r_state;

  // Byte holding register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_src   <= '0;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      r_last     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= bus.req_data[w_grant_idx*DATA_W +: DATA_W];
      r_tx_src   <= w_grant_idx;
`ifdef UART_ARB_LOCK_EN
      r_last     <= bus.req_last[w_grant_idx];
`endif
    end else if (w_tx_fire) begin
      r_tx_valid <= 1'b0;
      r_ptr      <= r_tx_src;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model and a tx scoreboard.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: {src, data} of each byte the model expects on tx_*
  logic [IW+DW-1:0] exp_q[$];
  logic [IW-1:0]    src_log[$];

  // reference model state
  int  m_ptr;
  bit  m_held;
  int  m_held_src;
  bit  m_held_last;
  bit  m_locked;
  int  m_owner;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = N - 1;
    m_held = 0;
    m_held_src = 0;
    m_held_last = 0;
    m_locked = 0;
    m_owner = 0;
    exp_q.delete();
  endtask

  // Hold rst for 'cycles' edges with every requester valid; returns at posedge+1.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = 32'hDEAD_BEEF;
    bus.req_last  = '1;
    bus.tx_ready  = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_tx_src", 32'(bus.tx_src), 32'h0);
  endtask

  // Drive one cycle of inputs (called at posedge+1), check at negedge against
  // the model, advance the model to the next edge. acc = bytes the DUT accepted.
  task automatic step(input logic [N-1:0] v, input logic [31:0] d,
                      input logic [N-1:0] l, input logic tr,
                      output logic [N-1:0] acc);
    logic [N-1:0] exp_rdy;
    int           g;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.tx_ready  = tr;
    @(negedge clk);
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_held));
    chk("busy", 32'(bus.busy), 32'(m_held || m_locked));
    exp_rdy = '0;
    g = -1;
    if (!m_held) begin
      if (m_locked) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = bus.req_ready & v;
    if (g >= 0) begin
      exp_q.push_back({IW'(g), d[g*DW +: DW]});
      m_held = 1;
      m_held_src = g;
      m_held_last = l[g];
    end else if (m_held && tr) begin
      m_held = 0;
      m_ptr = m_held_src;
`ifdef UART_ARB_LOCK_EN
      m_locked = !m_held_last;
      m_owner = m_held_src;
`endif
    end
    @(posedge clk); #1;
  endtask

  // monitor: pop and compare whenever the DUT hands a byte to the transmitter
  always @(negedge clk) begin
    logic [IW+DW-1:0] e;
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      src_log.push_back(bus.tx_src);
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(bus.tx_data), 32'(e[DW-1:0]));
        chk("tx_src", 32'(bus.tx_src), 32'(e[IW+DW-1:DW]));
      end
    end
  end

  initial begin
    logic [N-1:0] acc;
    int           grants;
    int           sent1;
    logic [IW-1:0] exp_seq[4];

    model_reset();
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    @(posedge clk); #1;

    // reset with all requesters valid; first grant goes to req 0
    do_reset(2);
    step(4'b1111, 32'h4433_2211, 4'b1111, 1'b0, acc);
    chk("first_grant", 32'(acc), 32'h1);
    step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);

    // single byte from req 2
    step(4'b0100, 32'h0055_0000, 4'b1111, 1'b1, acc);
    chk("single_grant", 32'(acc), 32'h4);
    chk("single_tx_data", 32'(bus.tx_data), 32'h55);
    chk("single_tx_src", 32'(bus.tx_src), 32'h2);
    step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);

    // round robin, all valid, tx_ready high: one byte every 2 cycles
    do_reset(1);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, $urandom, 4'b1111, 1'b1, acc);
      if (acc != 0) grants++;
    end
    chk("rr_rate", 32'(grants), 32'd5);

    // backpressure: byte A3 held for 5 stalled cycles
    step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);
    step(4'b0010, 32'h0000_A300, 4'b1111, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, $urandom, 4'b1111, 1'b0, acc);
      chk("bp_hold_data", 32'(bus.tx_data), 32'hA3);
    end
    step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);
    chk("bp_done", 32'(bus.tx_valid), 32'h0);

    // reset while a byte is held: byte dropped, ptr back to NUM_REQ-1
    step(4'b0100, 32'h0077_0000, 4'b1111, 1'b0, acc);
    step(4'b0000, 32'h0, 4'b1111, 1'b0, acc);
    do_reset(1);
    step(4'b1111, $urandom, 4'b1111, 1'b1, acc);
    chk("post_rst_grant", 32'(acc), 32'h1);
    step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);

    // message scenario: ptr parked at 0, req1 sends 3 bytes, req0 always valid
    do_reset(1);
    step(4'b0001, $urandom, 4'b1111, 1'b1, acc);
    step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);
    src_log.delete();
    sent1 = 0;
    for (int i = 0; i < 12; i++) begin
      step({2'b00, sent1 < 3, 1'b1}, $urandom, {2'b00, sent1 == 2, 1'b1}, 1'b1, acc);
      if (acc[1]) sent1++;
    end
`ifdef UART_ARB_LOCK_EN
    exp_seq = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_seq = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
    chk("msg_count_ok", 32'(src_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < src_log.size()) chk("msg_src_seq", 32'(src_log[i]), 32'(exp_seq[i]));
    end

    // randomized traffic
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      step(N'($urandom_range(0, 15)), $urandom, N'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), acc);
    end

    // drain and make sure nothing was left unaccounted for
    for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 4'b1111, 1'b1, acc);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
